mem_transfer_ctrl: RTL and testbench

MEM_TRANSFER_CTRL -- requirements
Module: mem_transfer_ctrl

---
 rtl/mem_transfer_ctrl.sv | 80 ++++++++
 tb/tb_mem_transfer_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_transfer_ctrl.sv
// mem_transfer_ctrl: copies count words between main and storage memory (STD: main->stor, LDD: stor->main)
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   trSTD, trLDD           level transfer requests (STD wins when both are high)
//   baseMain, baseStor     start addresses, count = words to move (latched at start)
//   cpuAddr/cpuWdata/cpuWe CPU access to main memory, passed through when idle
//   main*/stor*            synchronous-read memory ports, 1-cycle read latency
//   waitTR                 stall to the control unit
//   done                   one-cycle completion pulse
module mem_transfer_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       trSTD,
    input  logic       trLDD,
    input  logic [7:0] baseMain,
    input  logic [7:0] baseStor,
    input  logic [7:0] count,
    input  logic [7:0] cpuAddr,
    input  logic [7:0] cpuWdata,
    input  logic       cpuWe,
    output logic [7:0] mainAddr,
    output logic [7:0] mainWdata,
    output logic       mainWe,
    input  logic [7:0] mainRdata,
    output logic [7:0] storAddr,
    output logic [7:0] storWdata,
    output logic       storWe,
    input  logic [7:0] storRdata,
    output logic       waitTR,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} stateT;
    stateT state, nextState;
    logic isStd, doneSeen, busy, start, last;
    logic [7:0] mainBase, storBase, cnt, idx;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            isStd    <= 1'b0;
            mainBase <= '0;
            storBase <= '0;
            cnt      <= '0;
            idx      <= '0;
            doneSeen <= 1'b0;
        end else begin
            state    <= nextState;
            doneSeen <= state == DONE;
            if (start) begin
                isStd    <= trSTD;
                mainBase <= baseMain;
                storBase <= baseStor;
                cnt      <= count;
                idx      <= '0;
            end else if (state == WR && !last) begin
                idx <= idx + 8'd1;
            end
        end
    end
    // Write strobes are masked by rst so a reset landing on a WR cycle drops that word.
    always_comb begin
        busy      = state == RD || state == WR;
        start     = state == IDLE && (trSTD || trLDD) && count != 8'd0;
        last      = idx == cnt - 8'd1;
        waitTR    = busy || start;
        done      = state == DONE && !doneSeen;
        mainAddr  = busy ? mainBase + idx : cpuAddr;
        mainWdata = busy ? storRdata : cpuWdata;
        mainWe    = busy ? state == WR && !isStd && !rst : cpuWe;
        storAddr  = storBase + idx;
        storWdata = mainRdata;
        storWe    = state == WR && isStd && !rst;
        nextState = state;
        case (state)
            IDLE:    nextState = (trSTD || trLDD) ? (count != 8'd0 ? RD : DONE) : IDLE;
            RD:      nextState = WR;
            WR:      nextState = last ? DONE : RD;
            default: nextState = (trSTD || trLDD) ? DONE : IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_transfer_ctrl.sv
// tb_mem_transfer_ctrl: directed checks of mem_transfer_ctrl against behavioural memories
module tb_mem_transfer_ctrl;
    logic clk, rst, trSTD, trLDD, cpuWe, mainWe, storWe, waitTR, done;
    logic [7:0] baseMain, baseStor, count, cpuAddr, cpuWdata;
    logic [7:0] mainAddr, mainWdata, mainRdata, storAddr, storWdata, storRdata;
    logic [7:0] mainMem [256];
    logic [7:0] storMem [256];
    int checks = 0, errors = 0;

    mem_transfer_ctrl dut (
        .clk(clk), .rst(rst), .trSTD(trSTD), .trLDD(trLDD),
        .baseMain(baseMain), .baseStor(baseStor), .count(count),
        .cpuAddr(cpuAddr), .cpuWdata(cpuWdata), .cpuWe(cpuWe),
        .mainAddr(mainAddr), .mainWdata(mainWdata), .mainWe(mainWe), .mainRdata(mainRdata),
        .storAddr(storAddr), .storWdata(storWdata), .storWe(storWe), .storRdata(storRdata),
        .waitTR(waitTR), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mainWe) mainMem[mainAddr] <= mainWdata;
        if (storWe) storMem[storAddr] <= storWdata;
        mainRdata <= mainMem[mainAddr];
        storRdata <= storMem[storAddr];
    end

    typedef struct {
        logic       s, l, we;
        logic [7:0] cnt, addr, wdata;
        logic       expWait, expWe;
        logic [7:0] expAddr, expWdata;
    } vecT;
    vecT vecs [6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic s, input logic l, input logic [7:0] bm, input logic [7:0] bs,
                        input logic [7:0] cnt, output logic firstWait, output int waitN,
                        output int doneN, output int sWeN, output int mWeN);
        int held;
        waitN = 0; doneN = 0; sWeN = 0; mWeN = 0; held = 0;
        tick();
        trSTD = s; trLDD = l; baseMain = bm; baseStor = bs; count = cnt;
        @(negedge clk);
        firstWait = waitTR;
        for (int i = 0; i < 40 && held < 6; i++) begin
            tick();
            baseMain = bm ^ 8'h5A; baseStor = bs ^ 8'hA5; count = cnt + 8'd7;
            if (held == 3) begin trSTD = 1'b0; trLDD = 1'b0; end
            @(negedge clk);
            if (waitTR) waitN++;
            if (done) doneN++;
            if (storWe) sWeN++;
            if (mainWe) mWeN++;
            if (doneN > 0) held++;
        end
    endtask

    logic fw;
    int wN, dN, sN, mN;

    initial begin
        for (int i = 0; i < 256; i++) begin mainMem[i] = 8'h00; storMem[i] = 8'h00; end
        mainMem[8'h10] = 8'hA1; mainMem[8'h11] = 8'hB2; mainMem[8'h12] = 8'hC3; mainMem[8'h13] = 8'hD4;
        mainMem[8'h20] = 8'h3C;
        storMem[8'hFE] = 8'h11; storMem[8'hFF] = 8'h22; storMem[8'h00] = 8'h33;
        storMem[8'h70] = 8'hEE; storMem[8'h71] = 8'hEE;
        vecs[0] = '{1'b0, 1'b0, 1'b1, 8'd3,   8'h05, 8'h5A, 1'b0, 1'b1, 8'h05, 8'h5A};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 8'd3,   8'h12, 8'h34, 1'b1, 1'b0, 8'h12, 8'h34};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 8'd1,   8'hC0, 8'h0F, 1'b1, 1'b1, 8'hC0, 8'h0F};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 8'd0,   8'h99, 8'h01, 1'b0, 1'b0, 8'h99, 8'h01};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 8'd0,   8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF, 8'hFF};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'hFF,  8'h00, 8'h80, 1'b1, 1'b0, 8'h00, 8'h80};
        rst = 1'b1; trSTD = 1'b0; trLDD = 1'b0; cpuWe = 1'b0;
        baseMain = 8'h00; baseStor = 8'h00; count = 8'h00; cpuAddr = 8'h33; cpuWdata = 8'h00;
        tick(); tick();
        @(negedge clk);
        chk("reset waitTR", int'(waitTR), 0);
        chk("reset storWe", int'(storWe), 0);
        chk("reset done", int'(done), 0);
        chk("reset mainAddr", int'(mainAddr), 'h33);
        tick();
        rst = 1'b0;
        // Idle-state combinational vectors; requests are withdrawn before the next edge.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            trSTD = vecs[i].s; trLDD = vecs[i].l; count = vecs[i].cnt;
            cpuAddr = vecs[i].addr; cpuWdata = vecs[i].wdata; cpuWe = vecs[i].we;
            #1;
            chk($sformatf("vec%0d waitTR", i), int'(waitTR), int'(vecs[i].expWait));
            chk($sformatf("vec%0d mainAddr", i), int'(mainAddr), int'(vecs[i].expAddr));
            chk($sformatf("vec%0d mainWdata", i), int'(mainWdata), int'(vecs[i].expWdata));
            chk($sformatf("vec%0d mainWe", i), int'(mainWe), int'(vecs[i].expWe));
            chk($sformatf("vec%0d storWe", i), int'(storWe), 0);
            chk($sformatf("vec%0d done", i), int'(done), 0);
            trSTD = 1'b0; trLDD = 1'b0; cpuWe = 1'b0;
        end
        // STD, 3 words
        xfer(1'b1, 1'b0, 8'h10, 8'h40, 8'd3, fw, wN, dN, sN, mN);
        chk("std waitTR at request", int'(fw), 1);
        chk("std waitTR cycles after request", wN, 6);
        chk("std done pulses", dN, 1);
        chk("std storWe cycles", sN, 3);
        chk("std mainWe cycles", mN, 0);
        chk("std stor40", int'(storMem[8'h40]), 'hA1);
        chk("std stor41", int'(storMem[8'h41]), 'hB2);
        chk("std stor42", int'(storMem[8'h42]), 'hC3);
        // LDD with storage address wrap
        xfer(1'b0, 1'b1, 8'h80, 8'hFE, 8'd3, fw, wN, dN, sN, mN);
        chk("ldd waitTR cycles", wN, 6);
        chk("ldd done pulses", dN, 1);
        chk("ldd storWe cycles", sN, 0);
        chk("ldd main80", int'(mainMem[8'h80]), 'h11);
        chk("ldd main81", int'(mainMem[8'h81]), 'h22);
        chk("ldd main82", int'(mainMem[8'h82]), 'h33);
        // count = 0
        xfer(1'b1, 1'b0, 8'h10, 8'h50, 8'd0, fw, wN, dN, sN, mN);
        chk("zero waitTR at request", int'(fw), 0);
        chk("zero waitTR cycles", wN, 0);
        chk("zero storWe cycles", sN, 0);
        chk("zero done pulses", dN, 1);
        chk("zero stor50", int'(storMem[8'h50]), 0);
        // both requests: STD wins
        xfer(1'b1, 1'b1, 8'h10, 8'h60, 8'd1, fw, wN, dN, sN, mN);
        chk("both waitTR cycles", wN, 2);
        chk("both storWe cycles", sN, 1);
        chk("both mainWe cycles", mN, 0);
        chk("both stor60", int'(storMem[8'h60]), 'hA1);
        chk("both main10", int'(mainMem[8'h10]), 'hA1);
        // reset during the second WR of a 4-word STD
        tick();
        trSTD = 1'b1; baseMain = 8'h10; baseStor = 8'h70; count = 8'd4;
        tick();
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("mid WR1 storWe before reset", int'(storWe), 1);
        rst = 1'b1; trSTD = 1'b0;
        #1;
        chk("mid WR1 storWe under reset", int'(storWe), 0);
        @(posedge clk);
        #1;
        rst = 1'b0; cpuAddr = 8'h33;
        @(negedge clk);
        chk("post-reset waitTR", int'(waitTR), 0);
        chk("post-reset storWe", int'(storWe), 0);
        chk("post-reset mainAddr", int'(mainAddr), 'h33);
        chk("mid stor70", int'(storMem[8'h70]), 'hA1);
        chk("mid stor71", int'(storMem[8'h71]), 'hEE);
        // CPU write ignored while busy, honoured when idle
        tick();
        trSTD = 1'b1; baseMain = 8'h20; baseStor = 8'h90; count = 8'd1;
        tick();
        cpuWe = 1'b1; cpuAddr = 8'h05; cpuWdata = 8'h77;
        @(negedge clk);
        chk("cpu in RD mainWe", int'(mainWe), 0);
        chk("cpu in RD mainAddr", int'(mainAddr), 'h20);
        tick();
        cpuWe = 1'b0;
        tick();
        trSTD = 1'b0;
        tick();
        tick();
        chk("cpu in RD main05", int'(mainMem[8'h05]), 0);
        chk("cpu xfer stor90", int'(storMem[8'h90]), 'h3C);
        cpuWe = 1'b1; cpuAddr = 8'h05; cpuWdata = 8'h77;
        tick();
        cpuWe = 1'b0;
        chk("cpu in IDLE main05", int'(mainMem[8'h05]), 'h77);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
